// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Frame: MAGIC, LEN_HI, LEN_LO, N big-endian 32-bit words, XOR checksum byte.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMagic,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StErr
  } state_t;

  localparam logic [7:0] MAGIC = 8'h5A;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 5_000_000;

endpackage

// File: rtl/prog_loader_timeout.sv
// Reloadable inter-byte timeout counter.
// Asserts expired once TIMEOUT_CYC enabled cycles have passed since the last clear.
module prog_loader_timeout
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  // Loading TIMEOUT_CYC-1 makes the expiry fall on the TIMEOUT_CYC-th idle cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CW'(TIMEOUT_CYC - 1);
    end else if (enable && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = enable && !clear && (cnt_q == '0);

endmodule

// File: rtl/prog_loader.sv
// UART program loader: parses a framed byte stream into program-memory writes
// while holding the CPU, and reports done/error once the checksum is known.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d, len_next;
  logic [ADDR_W:0]   word_q, word_d;
  logic [1:0]        byte_q, byte_d;
  logic [31:0]       asm_q, asm_d, asm_next;
  logic [7:0]        chk_q, chk_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              timed, expired, len_bad;

  assign timed    = state_q inside {StLenHi, StLenLo, StData, StCheck};
  assign len_next = {len_q[15:8], rx_data};
  assign asm_next = {asm_q[23:0], rx_data};
  // N may equal the full memory size, hence the ADDR_W+1-bit word counter.
  assign len_bad  = (len_next == 16'd0) || ({16'd0, len_next} > (32'd1 << ADDR_W));

  prog_loader_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_valid || !timed),
    .enable (timed),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    word_d    = word_q;
    byte_d    = byte_q;
    asm_d     = asm_q;
    chk_d     = chk_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    error_d   = error_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMagic;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      StMagic: begin
        if (rx_valid && rx_data == MAGIC) state_d = StLenHi;
      end
      StLenHi: begin
        if (rx_valid) begin
          len_d[15:8] = rx_data;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (rx_valid) begin
          len_d   = len_next;
          word_d  = '0;
          byte_d  = '0;
          asm_d   = '0;
          chk_d   = '0;
          state_d = len_bad ? StErr : StData;
        end
      end
      StData: begin
        if (rx_valid) begin
          asm_d  = asm_next;
          chk_d  = chk_q ^ rx_data;
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = word_q[ADDR_W-1:0];
            wr_data_d = asm_next;
            word_d    = word_q + (ADDR_W + 1)'(1);
            if (32'(word_q) + 32'd1 == {16'd0, len_q}) state_d = StCheck;
          end
        end
      end
      StCheck: begin
        if (rx_valid) state_d = (rx_data == chk_q) ? StDone : StErr;
      end
      StDone, StErr: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (expired) state_d = StErr;
    if (state_q != StDone && state_d == StDone) done_d = 1'b1;
    if (state_q != StErr && state_d == StErr) error_d = 1'b1;

    hold_d = state_d inside {StMagic, StLenHi, StLenLo, StData, StCheck, StErr};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      asm_q     <= '0;
      chk_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      asm_q     <= asm_d;
      chk_q     <= chk_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, junk prefix, length limits,
// inter-byte timeout and mid-frame reset.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned TOUT   = 100;

  logic              clock = 1'b0;
  logic              reset, start, rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en, cpu_hold, done, error;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int nw      = 0;
  int base;
  logic [31:0] w_addr[0:15];
  logic [31:0] w_data[0:15];

  prog_loader #(
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .error   (error)
  );

  always #5 clock = ~clock;

  // One log entry per negedge that sees wr_en, so a two-cycle strobe shows up as two writes.
  always @(negedge clock) begin
    if (wr_en) begin
      if (nw < 16) begin
        w_addr[nw] = 32'(wr_addr);
        w_data[nw] = wr_data;
      end
      nw = nw + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clock);
  endtask

  // Two words 0x00000008, 0x24010005; XOR of their bytes is 0x28.
  task automatic send_frame(input logic [7:0] chk);
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'h24); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
    send_byte(chk);
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(negedge clock);
  endtask

  task automatic end_load();
    start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Good frame preceded by junk bytes.
    base = nw;
    begin_load();
    check("start_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h00); send_byte(8'hFF);
    send_frame(8'h28);
    check("good_nwrites", 32'(nw - base), 32'd2);
    check("good_addr0", w_addr[base], 32'd0);
    check("good_data0", w_data[base], 32'h0000_0008);
    check("good_addr1", w_addr[base+1], 32'd1);
    check("good_data1", w_data[base+1], 32'h2401_0005);
    check("good_done", 32'(done), 32'd1);
    check("good_error", 32'(error), 32'd0);
    check("good_hold", 32'(cpu_hold), 32'd0);
    end_load();
    check("done_sticky", 32'(done), 32'd1);

    // Bad checksum.
    base = nw;
    begin_load();
    check("restart_clr_done", 32'(done), 32'd0);
    send_frame(8'h29);
    repeat (3) @(negedge clock);
    check("bad_nwrites", 32'(nw - base), 32'd2);
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_hold", 32'(cpu_hold), 32'd1);
    end_load();
    check("bad_idle_hold", 32'(cpu_hold), 32'd0);
    check("error_sticky", 32'(error), 32'd1);

    // Length limits.
    base = nw;
    begin_load();
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00);
    check("len0_error", 32'(error), 32'd1);
    end_load();
    begin_load();
    send_byte(8'h5A); send_byte(8'h40); send_byte(8'h01);
    check("len4001_error", 32'(error), 32'd1);
    check("len_nwrites", 32'(nw - base), 32'd0);
    end_load();

    // Timeout after two bytes of a word.
    begin_load();
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TOUT - 2) @(negedge clock);
    check("tout_early", 32'(error), 32'd0);
    @(negedge clock);
    check("tout_fire", 32'(error), 32'd1);
    check("tout_hold", 32'(cpu_hold), 32'd1);
    end_load();

    // Reset after the first write of a frame.
    base = nw;
    begin_load();
    send_byte(8'h5A); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    send_byte(8'h24); send_byte(8'h01);
    check("mid_nwrites", 32'(nw - base), 32'd1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("mid_rst_wr_data", wr_data, 32'd0);
    check("mid_rst_hold", 32'(cpu_hold), 32'd0);
    check("mid_rst_flags", 32'({done, error}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    base = nw;
    begin_load();
    send_frame(8'h28);
    check("post_rst_nwrites", 32'(nw - base), 32'd2);
    check("post_rst_data1", w_data[base+1], 32'h2401_0005);
    check("post_rst_done", 32'(done), 32'd1);
    end_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
